// File: rtl/vga_sync_gen.sv
// Vertical half of a VGA timing generator: counts lines from the horizontal
// counter's tick and registers sync, blanking and pixel coordinates.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOTAL   = 525,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [9:0] hcnt,
  input  logic       ts,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] vcnt,
  output logic       frame_start,
  output logic       hcnt_err
);

  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  // The horizontal counter upstream always runs 800 pixels per line.
  localparam logic [9:0] H_TOTAL  = 10'd800;

  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic       hs_act_p0;
  logic       vs_act_p0;
  logic       vis_p0;
  logic       vwrap_p0;
  logic [9:0] vcnt_nxt_p0;

  // Stage p0: decode the sampled hcnt and the current (pre-update) line.
  always_comb begin
    hs_act_p0   = (hcnt >= HS_START) && (hcnt < HS_END);
    vs_act_p0   = (vcnt >= VS_START) && (vcnt < VS_END);
    vis_p0      = (hcnt < H_VIS) && (vcnt < V_VIS);
    vwrap_p0    = ts && (vcnt == V_LAST);
    vcnt_nxt_p0 = vcnt;
    if (ts) begin
      vcnt_nxt_p0 = vwrap_p0 ? 10'd0 : vcnt + 10'd1;
    end
  end

  // Stage p1: registered outputs, advanced only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcnt        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      hcnt_err    <= 1'b0;
    end else begin
      // Single-cycle pulse: cleared on any edge where no wrap happens.
      frame_start <= en && vwrap_p0;
      if (en) begin
        vcnt     <= vcnt_nxt_p0;
        hsync    <= sync_level(hs_act_p0);
        vsync    <= sync_level(vs_act_p0);
        video_on <= vis_p0;
        x        <= vis_p0 ? hcnt : 10'd0;
        y        <= vis_p0 ? vcnt : 10'd0;
        hcnt_err <= hcnt_err | (hcnt >= H_TOTAL);
      end
    end
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, pixels.
REQ-004 SHALL have parameter V_VISIBLE, default 480: visible lines per frame.
REQ-005 SHALL have parameter V_FP, default 10: vertical front porch, lines.
REQ-006 SHALL have parameter V_SYNC, default 2: vsync width, lines.
REQ-007 SHALL have parameter V_TOTAL, default 525: lines per frame.
REQ-008 SHALL have parameter SYNC_POL, default 0: sync active level (0 = active-low).
REQ-009 SHALL have port clk, input, 1: the single divided pixel clock, which is the only clock.
REQ-010 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-011 SHALL have port en, input, 1: pixel enable, the same signal that drives the horizontal counter.
REQ-012 SHALL have port hcnt, input, 10: horizontal count, 0..799, from the horizontal counter.
REQ-013 SHALL have port ts, input, 1: line tick from the horizontal counter, high after each 799->0 wrap.
REQ-014 SHALL have port hsync, output, 1: registered horizontal sync.
REQ-015 SHALL have port vsync, output, 1: registered vertical sync.
REQ-016 SHALL have port video_on, output, 1: registered visible-area flag.
REQ-017 SHALL have port x, output, 10: registered pixel column, 0 outside the visible area.
REQ-018 SHALL have port y, output, 10: registered pixel row, 0 outside the visible area.
REQ-019 SHALL have port vcnt, output, 10: internal vertical line counter, 0..V_TOTAL-1.
REQ-020 SHALL have port frame_start, output, 1: one-clk pulse on each frame wrap.
REQ-021 SHALL have port hcnt_err, output, 1: sticky flag set when hcnt>=800 is sampled.

Function
REQ-022 SHALL update all state and outputs only on rising clk edges where en=1, and SHALL hold them when en=0, except frame_start (REQ-028).
REQ-023 SHALL advance vcnt by 1 on an en=1 edge with ts=1, and SHALL wrap vcnt from V_TOTAL-1 to 0.
REQ-024 SHALL keep vcnt unchanged on en=1 edges with ts=0, and SHALL ignore ts when en=0.
REQ-025 SHALL register hsync at the active level iff H_VISIBLE+H_FP <= hcnt < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults), and at the inactive level otherwise.
REQ-026 SHALL register vsync at the active level iff V_VISIBLE+V_FP <= vcnt(pre-update) < V_VISIBLE+V_FP+V_SYNC (490..491 at defaults).
REQ-027 SHALL register video_on=1, x=hcnt and y=vcnt(pre-update) iff hcnt<H_VISIBLE and vcnt<V_VISIBLE; otherwise it SHALL register video_on=0, x=0 and y=0.
REQ-028 SHALL assert frame_start for exactly one clk on the edge where vcnt wraps to 0, and SHALL clear it on the next clk edge regardless of en.
REQ-029 SHALL set hcnt_err on any en=1 edge with hcnt>=800, and SHALL clear it only by reset.
REQ-030 SHALL still decode hsync normally when hcnt>=800 is sampled, giving the inactive level, with x=0 and video_on=0.
REQ-031 SHALL produce outputs with one enabled-clk latency, where all outputs reflect the hcnt/vcnt values sampled at the previous en=1 edge.
REQ-032 SHALL use sync polarity such that the active level = SYNC_POL and the inactive level = ~SYNC_POL.

Reset
REQ-033 SHALL, while rst=1, force immediately (asynchronously): vcnt=0, hsync=vsync=~SYNC_POL, video_on=0, x=0, y=0, frame_start=0, hcnt_err=0.
REQ-034 SHALL resume operation on the first en=1 edge after rst falls, and SHALL discard any partial frame or pending frame_start state when rst is asserted mid-frame.

Verification
REQ-035 SHALL be verified with: en=1, hcnt stepping 0..799 and ts per line -> hsync low for exactly hcnt 656..751 (output one clk later), and video_on high for hcnt 0..639 on line 0.
REQ-036 SHALL be verified with: drive 525 ts pulses -> vcnt 524->0, frame_start high for exactly 1 clk, and vsync low only while vcnt=490..491 is sampled.
REQ-037 SHALL be verified with: hcnt=100, vcnt=479 -> x=100, y=479, video_on=1; then hcnt=100, vcnt=480 -> x=0, y=0, video_on=0.
REQ-038 SHALL be verified with: en=0 for 5 clks while ts=1 and hcnt changes -> vcnt and all outputs held, and no frame_start.
REQ-039 SHALL be verified with: hcnt=850 at en=1 -> hcnt_err=1 and it stays 1 until rst; hsync stays high.
REQ-040 SHALL be verified with: rst pulsed asynchronously mid-frame at vcnt=300 -> all outputs at reset values before the next clk edge, and vcnt restarts at 0.
